instr_mem_sync: RTL and testbench

- Parametrised, writable successor to the fixed combinational instruction ROM.
- Provides synchronous single-cycle-latency instruction fetch to the accumulator CPU front end.
- Loader write port lets a host or debug block download a program at run time.
- Self-initialising: after reset an init FSM fills the array with NOP, or with the boot program (see Optional Feature), before accepting traffic.

---
 rtl/instr_mem_sync_if.sv | 36 +++
 rtl/instr_mem_sync.sv | 111 +++++++++++
 tb/tb_instr_mem_sync.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_sync_if.sv
// rtl/instr_mem_sync_if.sv - fetch and loader bus for instr_mem_sync
// Ports (all signals; direction shown for the slave side, i.e. the memory):
//   fetch_req   in   fetch request, sampled each clk
//   fetch_addr  in   fetch address (AW)
//   fetch_valid out  one-cycle pulse, fetch_data holds the response
//   fetch_data  out  fetched instruction word (DW)
//   ld_we       in   loader write strobe
//   ld_addr     in   loader write address (AW)
//   ld_data     in   loader write data (DW)
//   ld_err      out  one-cycle pulse on a rejected loader write
//   ready       out  high once initialisation is complete
// master = CPU front end / loader side, slave = memory side.
interface instr_mem_sync_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_err;
  logic          ready;

  modport master (
    output fetch_req, fetch_addr, ld_we, ld_addr, ld_data,
    input  fetch_valid, fetch_data, ld_err, ready
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_we, ld_addr, ld_data,
    output fetch_valid, fetch_data, ld_err, ready
  );
endinterface

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - writable instruction memory with sync fetch and self-init
// Purpose: DEPTH x DW instruction store. After reset an init sequence fills every
//   word (NOP_WORD, or the boot program when INSTR_MEM_BOOT_PROG_EN is defined),
//   taking exactly DEPTH cycles, then fetches and loader writes are served.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of instr_mem_sync_if (fetch port, loader port, ld_err, ready)
// Optional build macro: INSTR_MEM_BOOT_PROG_EN (boot program at addresses 0..5).
module instr_mem_sync #(
  parameter int         DW       = 8,
  parameter int         AW       = 8,
  parameter int         DEPTH    = 256,
  parameter logic [7:0] NOP_WORD = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  instr_mem_sync_if.slave bus
);
  localparam int            IW   = $clog2(DEPTH);
  localparam logic [DW-1:0] NOP  = DW'(NOP_WORD);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] init_word;
  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] ld_idx;
  logic          fetch_in_range;
  logic          ld_in_range;
  logic          collide;

  // Range checks use the full address so aliases above DEPTH never touch storage.
  assign fetch_in_range = 32'(bus.fetch_addr) < 32'(DEPTH);
  assign ld_in_range    = 32'(bus.ld_addr) < 32'(DEPTH);
  assign fetch_idx      = bus.fetch_addr[IW-1:0];
  assign ld_idx         = bus.ld_addr[IW-1:0];
  // Write-first: a same-cycle write to the fetched word bypasses the array.
  assign collide        = bus.ld_we && (bus.ld_addr == bus.fetch_addr);

`ifdef INSTR_MEM_BOOT_PROG_EN
  always_comb begin
    init_word = NOP;
    case (init_cnt)
      IW'(0):  init_word = DW'(8'hD7);
      IW'(1):  init_word = DW'(8'h51);
      IW'(2):  init_word = DW'(8'hD9);
      IW'(3):  init_word = DW'(8'h11);
      IW'(4):  init_word = DW'(8'h00);
      IW'(5):  init_word = DW'(8'hF0);
      default: init_word = NOP;
    endcase
  end
`else
  assign init_word = NOP;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= INIT;
      init_cnt        <= '0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_data  <= NOP;
      bus.ld_err      <= 1'b0;
      bus.ready       <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          bus.fetch_valid <= 1'b0;
          bus.fetch_data  <= NOP;
          bus.ld_err      <= 1'b0;
          // The last word is written on this edge; ready shows from the next cycle.
          if (init_cnt == LAST) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          bus.ready       <= 1'b1;
          bus.ld_err      <= bus.ld_we && !ld_in_range;
          bus.fetch_valid <= bus.fetch_req;
          if (bus.fetch_req) begin
            if (!fetch_in_range)
              bus.fetch_data <= NOP;
            else if (collide)
              bus.fetch_data <= bus.ld_data;
            else
              bus.fetch_data <= mem[fetch_idx];
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage is not reset; the init sequence rewrites every word instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[init_cnt] <= init_word;
      else if (bus.ld_we && ld_in_range)
        mem[ld_idx] <= bus.ld_data;
    end
  end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - self-checking bench for instr_mem_sync (three configurations)
module tb_instr_mem_sync;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults; 1: DEPTH=64; 2: DW=16, AW=10, DEPTH=1000.
  logic        rst_i    [3];
  logic        req_i    [3];
  logic [9:0]  addr_i   [3];
  logic        we_i     [3];
  logic [9:0]  ldaddr_i [3];
  logic [15:0] lddata_i [3];

  logic        dv [3];
  logic [15:0] dd [3];
  logic        de [3];
  logic        dr [3];

  instr_mem_sync_if #(.DW(8),  .AW(8))  bus0 ();
  instr_mem_sync_if #(.DW(8),  .AW(8))  bus1 ();
  instr_mem_sync_if #(.DW(16), .AW(10)) bus2 ();

  assign bus0.fetch_req  = req_i[0];
  assign bus0.fetch_addr = addr_i[0][7:0];
  assign bus0.ld_we      = we_i[0];
  assign bus0.ld_addr    = ldaddr_i[0][7:0];
  assign bus0.ld_data    = lddata_i[0][7:0];
  assign bus1.fetch_req  = req_i[1];
  assign bus1.fetch_addr = addr_i[1][7:0];
  assign bus1.ld_we      = we_i[1];
  assign bus1.ld_addr    = ldaddr_i[1][7:0];
  assign bus1.ld_data    = lddata_i[1][7:0];
  assign bus2.fetch_req  = req_i[2];
  assign bus2.fetch_addr = addr_i[2];
  assign bus2.ld_we      = we_i[2];
  assign bus2.ld_addr    = ldaddr_i[2];
  assign bus2.ld_data    = lddata_i[2];

  assign dv[0] = bus0.fetch_valid;
  assign dd[0] = {8'h00, bus0.fetch_data};
  assign de[0] = bus0.ld_err;
  assign dr[0] = bus0.ready;
  assign dv[1] = bus1.fetch_valid;
  assign dd[1] = {8'h00, bus1.fetch_data};
  assign de[1] = bus1.ld_err;
  assign dr[1] = bus1.ready;
  assign dv[2] = bus2.fetch_valid;
  assign dd[2] = bus2.fetch_data;
  assign de[2] = bus2.ld_err;
  assign dr[2] = bus2.ready;

  instr_mem_sync #(.DW(8), .AW(8), .DEPTH(256), .NOP_WORD(8'h00)) u0 (
    .clk(clk), .rst(rst_i[0]), .bus(bus0));
  instr_mem_sync #(.DW(8), .AW(8), .DEPTH(64), .NOP_WORD(8'h00)) u1 (
    .clk(clk), .rst(rst_i[1]), .bus(bus1));
  instr_mem_sync #(.DW(16), .AW(10), .DEPTH(1000), .NOP_WORD(8'h00)) u2 (
    .clk(clk), .rst(rst_i[2]), .bus(bus2));

  int n_vec = 0;
  int n_bad = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 256 : (k == 1) ? 64 : 1000;
  endfunction

  function automatic logic [15:0] dmask(input int k);
    return (k == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic int amask(input int k);
    return (k == 2) ? 1023 : 255;
  endfunction

  // Hand-written expected initial contents of the low addresses.
  function automatic logic [15:0] boot_exp(input int a);
`ifdef INSTR_MEM_BOOT_PROG_EN
    case (a)
      0: return 16'h00D7;
      1: return 16'h0051;
      2: return 16'h00D9;
      3: return 16'h0011;
      4: return 16'h0000;
      5: return 16'h00F0;
      default: return 16'h0000;
    endcase
`else
    return (a >= 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  // Behavioural model: contents known as soon as reset is seen; observable
  // behaviour is gated only by how many non-reset edges have elapsed.
  logic [15:0] mm [3][1024];
  int          edges [3];
  logic        ev [3];
  logic        ee [3];
  logic        er [3];
  logic [15:0] ed [3];
  bit          started [3];
  int          m_fa, m_la;

  initial for (int k = 0; k < 3; k++) started[k] = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      m_fa = int'(addr_i[k]) & amask(k);
      m_la = int'(ldaddr_i[k]) & amask(k);
      if (rst_i[k]) begin
        started[k] = 1'b1;
        edges[k]   = 0;
        ev[k] = 1'b0; ee[k] = 1'b0; er[k] = 1'b0; ed[k] = 16'h0000;
        for (int a = 0; a < dep(k); a++) mm[k][a] = boot_exp(a);
      end else if (edges[k] < dep(k)) begin
        edges[k] = edges[k] + 1;
        ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = 16'h0000;
        er[k] = (edges[k] == dep(k));
      end else begin
        er[k] = 1'b1;
        ev[k] = req_i[k];
        if (req_i[k]) begin
          if (m_fa >= dep(k))                 ed[k] = 16'h0000;
          else if (we_i[k] && (m_la == m_fa)) ed[k] = lddata_i[k] & dmask(k);
          else                                ed[k] = mm[k][m_fa];
        end
        ee[k] = we_i[k] && (m_la >= dep(k));
        if (we_i[k] && (m_la < dep(k))) mm[k][m_la] = lddata_i[k] & dmask(k);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (started[k]) begin
        n_vec++;
        if (dv[k] !== ev[k] || dd[k] !== ed[k] || de[k] !== ee[k] || dr[k] !== er[k]) begin
          n_bad++;
          $display("FAIL model_inst%0d t=%0t valid/data/err/ready got %b/%h/%b/%b want %b/%h/%b/%b",
                   k, $time, dv[k], dd[k], de[k], dr[k], ev[k], ed[k], ee[k], er[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1; req_i[k] = 1'b0; addr_i[k] = '0;
      we_i[k] = 1'b0; ldaddr_i[k] = '0; lddata_i[k] = '0;
    end
    repeat (3) tick();
    chk("reset_ready", 16'(dr[0]), 16'h0);
    chk("reset_valid", 16'(dv[0]), 16'h0);
    chk("reset_data",  dd[0],      16'h0);

    // Init with fetch and loader activity that must be ignored.
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b0;
    req_i[0] = 1'b1; addr_i[0] = 10'd0;
    we_i[0] = 1'b1; ldaddr_i[0] = 10'd5; lddata_i[0] = 16'h0099;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 200) we_i[0] = 1'b0;
      if (i == 63)  chk("init_k1_ready_63", 16'(dr[1]), 16'h0);
      if (i == 64)  chk("init_k1_ready_64", 16'(dr[1]), 16'h1);
      if (i == 255) chk("init_ready_255", 16'(dr[0]), 16'h0);
      if (i == 100) chk("init_valid_100", 16'(dv[0]), 16'h0);
    end
    chk("init_ready_256", 16'(dr[0]), 16'h1);
    chk("init_valid_256", 16'(dv[0]), 16'h0);

    // Back-to-back fetch of the low addresses.
    for (int i = 0; i < 7; i++) begin
      addr_i[0] = 10'(i);
      tick();
      chk("boot_valid", 16'(dv[0]), 16'h1);
      chk("boot_data", dd[0], boot_exp(i));
    end

    // Load then fetch, collision, independent addresses, hold.
    req_i[0] = 1'b0; we_i[0] = 1'b1; ldaddr_i[0] = 10'h10; lddata_i[0] = 16'h00A5;
    tick();
    chk("load_novalid", 16'(dv[0]), 16'h0);
    we_i[0] = 1'b0; req_i[0] = 1'b1; addr_i[0] = 10'h10;
    tick();
    chk("load_fetch_a5", dd[0], 16'h00A5);
    we_i[0] = 1'b1; ldaddr_i[0] = 10'h10; lddata_i[0] = 16'h003C;
    tick();
    chk("collide_3c", dd[0], 16'h003C);
    ldaddr_i[0] = 10'h20; lddata_i[0] = 16'h0077;
    tick();
    chk("indep_fetch", dd[0], 16'h003C);
    we_i[0] = 1'b0; addr_i[0] = 10'h20;
    tick();
    chk("indep_write", dd[0], 16'h0077);
    req_i[0] = 1'b0;
    tick();
    chk("hold_valid", 16'(dv[0]), 16'h0);
    chk("hold_data", dd[0], 16'h0077);

    // Out of range on the DEPTH=64 instance.
    req_i[1] = 1'b1; addr_i[1] = 10'h50;
    tick();
    chk("oor_valid", 16'(dv[1]), 16'h1);
    chk("oor_data", dd[1], 16'h0000);
    req_i[1] = 1'b0; we_i[1] = 1'b1; ldaddr_i[1] = 10'h50; lddata_i[1] = 16'h00EE;
    tick();
    chk("oor_err", 16'(de[1]), 16'h1);
    we_i[1] = 1'b0;
    tick();
    chk("oor_err_clear", 16'(de[1]), 16'h0);
    req_i[1] = 1'b1;
    for (int a = 0; a < 64; a++) begin
      addr_i[1] = 10'(a);
      tick();
      if (a == 16) chk("oor_alias_16", dd[1], boot_exp(16));
    end
    req_i[1] = 1'b0;

    // Parameter sweep instance.
    for (int i = 0; i < 1200 && dr[2] !== 1'b1; i++) tick();
    chk("sweep_ready", 16'(dr[2]), 16'h1);
    req_i[2] = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      addr_i[2] = 10'(a);
      tick();
    end
    req_i[2] = 1'b0; we_i[2] = 1'b1; ldaddr_i[2] = 10'd999; lddata_i[2] = 16'hBEEF;
    tick();
    chk("sweep_err_999", 16'(de[2]), 16'h0);
    ldaddr_i[2] = 10'd1000; lddata_i[2] = 16'h1234;
    tick();
    chk("sweep_err_1000", 16'(de[2]), 16'h1);
    for (int i = 0; i < 16; i++) begin
      ldaddr_i[2] = 10'((i * 61) % 999);
      lddata_i[2] = 16'hC000 | 16'((i * 61) % 999);
      tick();
    end
    we_i[2] = 1'b0; req_i[2] = 1'b1; addr_i[2] = 10'd999;
    tick();
    chk("sweep_fetch_999", dd[2], 16'hBEEF);
    addr_i[2] = 10'd1000;
    tick();
    chk("sweep_fetch_1000", dd[2], 16'h0000);
    for (int i = 0; i < 16; i++) begin
      addr_i[2] = 10'((i * 61) % 999);
      tick();
    end
    req_i[2] = 1'b0;

    // Reset mid-RUN and mid-INIT.
    we_i[0] = 1'b1; ldaddr_i[0] = 10'd0; lddata_i[0] = 16'h00FF;
    tick();
    we_i[0] = 1'b0; req_i[0] = 1'b1; addr_i[0] = 10'd0;
    tick();
    chk("overwrite_ff", dd[0], 16'h00FF);
    req_i[0] = 1'b0; rst_i[0] = 1'b1;
    tick();
    chk("rst_run_ready", 16'(dr[0]), 16'h0);
    rst_i[0] = 1'b0;
    repeat (100) tick();
    rst_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) chk("reinit_ready_255", 16'(dr[0]), 16'h0);
    end
    chk("reinit_ready_256", 16'(dr[0]), 16'h1);
    req_i[0] = 1'b1; addr_i[0] = 10'd0;
    tick();
    chk("reinit_addr0", dd[0], boot_exp(0));
    req_i[0] = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
